// File: rtl/data_sram_req_unit_if.sv
// data_sram_req_unit_if: pipeline request, SRAM-like data port and response signals
interface data_sram_req_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic [ADDR_W-1:0] resp_addr;
  logic              resp_addr_err;
  modport master (
    input  req_valid, req_wr, req_size, req_addr, req_wdata,
    input  data_addr_ok, data_data_ok, data_rdata, resp_ready,
    output req_ready, data_req, data_wr, data_size, data_addr, data_wdata,
    output resp_valid, resp_rdata, resp_addr, resp_addr_err
  );
  modport slave (
    output req_valid, req_wr, req_size, req_addr, req_wdata,
    output data_addr_ok, data_data_ok, data_rdata, resp_ready,
    input  req_ready, data_req, data_wr, data_size, data_addr, data_wdata,
    input  resp_valid, resp_rdata, resp_addr, resp_addr_err
  );
endinterface

// File: rtl/data_sram_req_unit.sv
// data_sram_req_unit: single-outstanding load/store to SRAM-like port; DATA_SRAM_ALIGN_CHECK_EN enables misalignment trapping
module data_sram_req_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic clk_i,
  input logic reset_i,
  data_sram_req_unit_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t            state_q, state_d;
  logic              wr_q, wr_d, err_q, err_d, mis;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d, repl, cap;
  assign repl = bus.req_size == 2'd0 ? {4{bus.req_wdata[7:0]}} :
                bus.req_size == 2'd1 ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
  assign cap = wr_q ? '0 : bus.data_rdata;
`ifdef DATA_SRAM_ALIGN_CHECK_EN
  assign mis = (bus.req_size == 2'd1 & bus.req_addr[0]) | (bus.req_size[1] & |bus.req_addr[1:0]);
`else
  assign mis = 1'b0;
`endif
  assign bus.req_ready     = state_q == IDLE & ~reset_i;
  assign bus.data_req      = state_q == REQ;
  assign bus.data_wr       = wr_q;
  assign bus.data_size     = size_q;
  assign bus.data_addr     = addr_q;
  assign bus.data_wdata    = wdata_q;
  assign bus.resp_valid    = state_q == RESP;
  assign bus.resp_rdata    = rdata_q;
  assign bus.resp_addr     = addr_q;
  assign bus.resp_addr_err = err_q;
  // next state and register updates for the one in-flight transaction
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        state_d = mis ? RESP : REQ;
        wr_d    = bus.req_wr;
        size_d  = bus.req_size;
        addr_d  = bus.req_addr;
        wdata_d = bus.req_wr ? repl : '0;
        rdata_d = '0;
        err_d   = mis;
      end
      REQ: if (bus.data_addr_ok) begin
        state_d = bus.data_data_ok ? RESP : WAIT;
        rdata_d = bus.data_data_ok ? cap : rdata_q;
      end
      WAIT: if (bus.data_data_ok) begin
        state_d = RESP;
        rdata_d = cap;
      end
      default: if (bus.resp_ready) begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
    endcase
  end
  // state and datapath registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_data_sram_req_unit.sv
// tb_data_sram_req_unit: directed table plus randomized transactions against a transaction-level model
module tb_data_sram_req_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  data_sram_req_unit_if bus ();
  data_sram_req_unit dut (.clk_i(clk), .reset_i(rst), .bus(bus));
  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdata, exp_wdata, exp_rdata;
    int          a, d, r;
  } vec_t;
  vec_t vecs[7];
  task automatic chk32(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask
  task automatic chk1(input string n, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", n, act, exp);
    end
  endtask
  function automatic logic mis_of(input logic [1:0] size, input logic [31:0] addr);
`ifdef DATA_SRAM_ALIGN_CHECK_EN
    return (size == 2'd1 && addr % 2 != 0) || (size >= 2'd2 && addr % 4 != 0);
`else
    return 1'b0;
`endif
  endfunction
  function automatic logic [31:0] repl_of(input logic [1:0] size, input logic [31:0] w);
    if (size == 2'd0) return (w & 32'hFF) * 32'h01010101;
    if (size == 2'd1) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction
  function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input logic [31:0] ew, input logic [31:0] er, input int a, input int d, input int r);
    vec_t v;
    v.wr = wr; v.size = size; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.exp_wdata = ew; v.exp_rdata = er; v.a = a; v.d = d; v.r = r;
    return v;
  endfunction
  // entered and left on a falling edge with the DUT in IDLE
  task automatic run(input vec_t v);
    logic mis;
    mis = mis_of(v.size, v.addr);
    chk1("idle_ready", bus.req_ready, 1'b1);
    bus.req_valid = 1'b1; bus.req_wr = v.wr; bus.req_size = v.size;
    bus.req_addr = v.addr; bus.req_wdata = v.wdata;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_addr = $urandom; bus.req_wdata = $urandom;
    if (!mis) begin
      for (int k = 0; k <= v.a; k++) begin
        chk1("data_req", bus.data_req, 1'b1);
        chk32("data_addr", bus.data_addr, v.addr);
        chk32("data_wdata", bus.data_wdata, v.exp_wdata);
        chk1("data_wr", bus.data_wr, v.wr);
        chk32("data_size", 32'(bus.data_size), 32'(v.size));
        chk1("resp_valid_in_req", bus.resp_valid, 1'b0);
        chk1("ready_busy", bus.req_ready, 1'b0);
        bus.data_rdata = $urandom;
        if (k == v.a) begin
          bus.data_addr_ok = 1'b1;
          bus.data_data_ok = v.d == 0;
          if (v.d == 0) bus.data_rdata = v.rdata;
        end
        @(negedge clk);
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
      end
      for (int j = 1; j <= v.d; j++) begin
        chk1("wait_no_req", bus.data_req, 1'b0);
        chk1("wait_no_resp", bus.resp_valid, 1'b0);
        bus.data_rdata = $urandom;
        if (j == v.d) begin
          bus.data_data_ok = 1'b1;
          bus.data_rdata = v.rdata;
        end
        @(negedge clk);
        bus.data_data_ok = 1'b0;
      end
    end
    for (int h = 0; h <= v.r; h++) begin
      chk1("resp_valid", bus.resp_valid, 1'b1);
      chk32("resp_rdata", bus.resp_rdata, mis ? 32'h0 : v.exp_rdata);
      chk32("resp_addr", bus.resp_addr, v.addr);
      chk1("resp_err", bus.resp_addr_err, mis);
      chk1("resp_no_req", bus.data_req, 1'b0);
      chk1("ready_in_resp", bus.req_ready, 1'b0);
      if (h < v.r) begin
        bus.req_valid = 1'b1; bus.req_addr = $urandom;
        bus.data_addr_ok = 1'($urandom); bus.data_data_ok = 1'($urandom); bus.data_rdata = $urandom;
      end else begin
        bus.req_valid = 1'b0; bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
        bus.resp_ready = 1'b1;
      end
      @(negedge clk);
    end
    bus.resp_ready = 1'b0;
    chk1("resp_drop", bus.resp_valid, 1'b0);
    chk1("err_clear", bus.resp_addr_err, 1'b0);
  endtask
  initial begin
    vec_t v;
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_size = 2'd0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = '0; bus.resp_ready = 1'b0;
    vecs[0] = mk(1'b0, 2'd2, 32'h1000, 32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 0, 2, 0);
    vecs[1] = mk(1'b1, 2'd0, 32'h2003, 32'h123456A5, 32'hFFFFFFFF, 32'hA5A5A5A5, 32'h0, 0, 0, 0);
    vecs[2] = mk(1'b1, 2'd1, 32'h2002, 32'hABCD1234, 32'h77777777, 32'h12341234, 32'h0, 5, 1, 0);
    vecs[3] = mk(1'b0, 2'd0, 32'h1003, 32'h5555AAAA, 32'h11223344, 32'h0, 32'h11223344, 1, 0, 3);
    vecs[4] = mk(1'b0, 2'd2, 32'h1002, 32'h0, 32'hCAFEF00D, 32'h0, 32'hCAFEF00D, 1, 0, 1);
    vecs[5] = mk(1'b1, 2'd3, 32'h3000, 32'h89ABCDEF, 32'h0BADCAFE, 32'h89ABCDEF, 32'h0, 2, 2, 0);
    vecs[6] = mk(1'b1, 2'd1, 32'h1001, 32'h0000BEEF, 32'h12121212, 32'hBEEFBEEF, 32'h0, 0, 3, 2);
    repeat (2) @(negedge clk);
    chk1("rst_data_req", bus.data_req, 1'b0);
    chk1("rst_resp_valid", bus.resp_valid, 1'b0);
    chk1("rst_req_ready", bus.req_ready, 1'b0);
    chk1("rst_err", bus.resp_addr_err, 1'b0);
    chk32("rst_data_addr", bus.data_addr, 32'h0);
    chk32("rst_data_wdata", bus.data_wdata, 32'h0);
    chk32("rst_resp_rdata", bus.resp_rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    foreach (vecs[i]) run(vecs[i]);
    bus.req_valid = 1'b1; bus.req_wr = 1'b0; bus.req_size = 2'd2; bus.req_addr = 32'h4000;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.data_addr_ok = 1'b1;
    @(negedge clk);
    bus.data_addr_ok = 1'b0;
    chk1("wait_before_rst", bus.data_req, 1'b0);
    rst = 1'b1; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h55555555;
    @(negedge clk);
    chk1("midrst_data_req", bus.data_req, 1'b0);
    chk1("midrst_resp_valid", bus.resp_valid, 1'b0);
    chk1("midrst_req_ready", bus.req_ready, 1'b0);
    chk32("midrst_resp_rdata", bus.resp_rdata, 32'h0);
    chk32("midrst_data_addr", bus.data_addr, 32'h0);
    rst = 1'b0; bus.data_data_ok = 1'b0;
    @(negedge clk);
    chk1("post_rst_ready", bus.req_ready, 1'b1);
    chk1("post_rst_resp", bus.resp_valid, 1'b0);
    for (int i = 0; i < 40; i++) begin
      v.wr = 1'($urandom); v.size = 2'($urandom); v.addr = $urandom;
      v.wdata = $urandom; v.rdata = $urandom;
      v.exp_wdata = v.wr ? repl_of(v.size, v.wdata) : 32'h0;
      v.exp_rdata = v.wr ? 32'h0 : v.rdata;
      v.a = int'($urandom_range(0, 3)); v.d = int'($urandom_range(0, 3)); v.r = int'($urandom_range(0, 2));
      run(v);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/data_sram_req_unit.md
Name: data_sram_req_unit

Overview:
- Upstream neighbour of the load data extractor in the MEM stage.
- Accepts one load/store per transaction from the pipeline and drives an SRAM-like data port (req/addr_ok/data_ok).
- For stores, replicates store data across byte lanes.
- Returns the raw 32-bit read word plus the latched byte address, so the downstream load extractor can select and extend bytes.
- Holds exactly one outstanding transaction.

Parameters:
- ADDR_W, 32, width of byte address.
- DATA_W, 32, width of data bus; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  pipeline presents a memory operation.
- req_ready  out  1  block accepts the operation this cycle.
- req_wr  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- data_req  out  1  SRAM-like request.
- data_wr  out  1  request is a write.
- data_size  out  2  copy of the latched size.
- data_addr  out  32  latched byte address, unmodified.
- data_wdata  out  32  lane-replicated store data.
- data_addr_ok  in  1  slave accepted the request.
- data_data_ok  in  1  slave returned data or write completion.
- data_rdata  in  32  read word from slave.
- resp_valid  out  1  transaction complete.
- resp_ready  in  1  downstream consumes the response.
- resp_rdata  out  32  raw read word; 0 for stores.
- resp_addr  out  32  latched byte address, used by the load extractor for lane select.
- resp_addr_err  out  1  misaligned access (see Optional Feature).

Behaviour:
- Reset:
  - State goes to IDLE.
  - data_req, resp_valid and resp_addr_err are 0.
  - data_* and resp_* data/address registers are 0.
  - req_ready is 0 during reset.
- Reset mid-operation: state returns to IDLE and any pending data_ok is discarded. The slave shares the same reset, so no stale data_ok arrives afterwards.
- FSM states:
  - IDLE:
    - req_ready = 1.
    - On req_valid, latch wr, size, addr and lane-replicated wdata, then go to REQ.
  - REQ:
    - data_req = 1; data_* outputs are stable.
    - On data_addr_ok, go to WAIT. data_req falls in the same cycle the FSM leaves REQ.
  - WAIT:
    - On data_data_ok, capture data_rdata (loads) or 0 (stores) into resp_rdata, then go to RESP.
    - data_addr_ok and data_data_ok may assert in the same cycle while in REQ. In that case go directly to RESP and capture the data.
  - RESP:
    - resp_valid = 1; resp_rdata and resp_addr are held.
    - On resp_ready, go to IDLE.
- Back-to-back: a new request is accepted only in IDLE. Minimum spacing is 1 cycle after resp_ready.
- Best-case latency: req accepted (cycle 0), data_req (cycle 1), addr_ok and data_ok (cycle 1), resp_valid (cycle 2).
- Store lane replication:
  - byte → {4{wdata[7:0]}}
  - half → {2{wdata[15:0]}}
  - word → wdata
- Loads:
  - data_wdata = 0.
  - resp_addr = latched req_addr; resp_rdata is not shifted.
- data_addr_ok and data_data_ok are ignored in IDLE and RESP.
- No request is ever dropped: data_req stays high until addr_ok.

Optional Feature:
- Macro: DATA_SRAM_ALIGN_CHECK_EN.
- Enabled:
  - In IDLE, a request is misaligned if it is half with addr[0]=1, or word with addr[1:0]≠0.
  - A misaligned request goes straight to RESP with no data_req.
  - resp_addr_err = 1, resp_rdata = 0, resp_addr = the faulting address.
  - resp_addr_err clears when leaving RESP.
- Disabled: resp_addr_err is tied to 0 and all addresses are forwarded to the slave unchanged.

Test Plan:
- Load word, addr 0x1000; slave gives addr_ok at +1 and data_ok at +3 with 0xDEADBEEF → resp_valid 4 cycles after accept, resp_rdata=0xDEADBEEF, resp_addr=0x1000.
- Store byte 0xA5, addr 0x2003; addr_ok and data_ok in the same cycle → data_wdata=0xA5A5A5A5, data_size=0, data_wr=1, resp_rdata=0, resp_valid on the next cycle.
- Store half 0x1234 at 0x2002 with addr_ok delayed 5 cycles → data_req held high and data_addr/data_wdata (0x12341234) stable for all 5 cycles.
- resp_ready held low for 3 cycles with req_valid asserted → req_ready=0 and resp_* stable until resp_ready; next request accepted the cycle after.
- reset asserted while in WAIT → next cycle data_req=0, resp_valid=0, req_ready=1 after reset deasserts.
- With DATA_SRAM_ALIGN_CHECK_EN, load word at 0x1002 → no data_req, resp_addr_err=1, resp_addr=0x1002; without the macro, data_req issued with data_addr=0x1002.
